// File: rtl/deck_shuffler_p.sv
// deck_shuffler_p
//   In-place Fisher-Yates shuffler for a deck held in an external card memory.
//   An optional fill phase writes ranks 1..13 repeating into addresses
//   0..DECK_SIZE-1. The shuffle then runs PASSES passes. Each pass draws a swap
//   index j in [i, DECK_SIZE-1], reads mem[i] and mem[j], and writes the two
//   values back swapped.
//   Every memory access takes two cycles. A read pulses o_MemClk in its first
//   cycle. A write pulses o_MemClk in its second cycle.
// Ports
//   clk          rising-edge clock
//   i_Rst_n      synchronous active-low reset
//   i_Start      start request, honoured only in IDLE or DONE
//   i_Init       1 = fill the deck before shuffling (sampled with i_Start)
//   i_ExtJ       1 = take swap index from i_Addr_J, 0 = internal LFSR
//   i_Addr_J     external swap index candidate
//   i_MemData    card memory read data
//   o_Address    card memory address (holds last value when idle)
//   o_Data       card memory write data (holds last value when idle)
//   o_MemClk     card memory clock strobe
//   o_Write      card memory write enable
//   o_Busy       operation in progress
//   o_Shuffled   shuffle complete, held until next start
//   vo_Addr_I    current index i (debug)
module deck_shuffler_p #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DECK_SIZE = 52,
  parameter int unsigned PASSES    = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              i_Rst_n,
  input  logic              i_Start,
  input  logic              i_Init,
  input  logic              i_ExtJ,
  input  logic [ADDR_W-1:0] i_Addr_J,
  input  logic [DATA_W-1:0] i_MemData,
  output logic [ADDR_W-1:0] o_Address,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_MemClk,
  output logic              o_Write,
  output logic              o_Busy,
  output logic              o_Shuffled,
  output logic [ADDR_W-1:0] vo_Addr_I
);

  localparam int unsigned LAST_ADDR = DECK_SIZE - 1;
  localparam int unsigned LAST_I    = DECK_SIZE - 2;

  typedef enum logic [3:0] {
    IDLE, FILL, DRAW, RD_I, RD_J, WR_J, WR_I, NEXT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic                ph_q, ph_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [ADDR_W-1:0]   i_q, i_d;
  logic [ADDR_W-1:0]   j_q, j_d;
  logic [ADDR_W-1:0]   fill_q, fill_d;
  logic [3:0]          pass_q, pass_d;
  logic [3:0]          rank_q, rank_d;
  logic                ext_q, ext_d;
  logic [DATA_W-1:0]   val_i_q, val_i_d;
  logic [DATA_W-1:0]   val_j_q, val_j_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                mem_clk, mem_wr;
  logic [ADDR_W-1:0]   cand;

  always_ff @(posedge clk) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      i_q     <= '0;
      j_q     <= '0;
      fill_q  <= '0;
      pass_q  <= '0;
      rank_q  <= 4'd1;
      ext_q   <= 1'b0;
      val_i_q <= '0;
      val_j_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      lfsr_q  <= lfsr_d;
      i_q     <= i_d;
      j_q     <= j_d;
      fill_q  <= fill_d;
      pass_q  <= pass_d;
      rank_q  <= rank_d;
      ext_q   <= ext_d;
      val_i_q <= val_i_d;
      val_j_q <= val_j_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    i_d     = i_q;
    j_d     = j_q;
    fill_d  = fill_q;
    pass_d  = pass_q;
    rank_d  = rank_q;
    ext_d   = ext_q;
    val_i_d = val_i_q;
    val_j_d = val_j_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mem_clk = 1'b0;
    mem_wr  = 1'b0;

    // Galois LFSR, x^16+x^14+x^13+x^11+1, free-running in every state
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    cand   = ext_q ? i_Addr_J : lfsr_q[ADDR_W-1:0];

    case (state_q)
      IDLE, DONE: begin
        if (i_Start) begin
          ext_d   = i_ExtJ;
          i_d     = '0;
          pass_d  = '0;
          rank_d  = 4'd1;
          fill_d  = '0;
          ph_d    = 1'b0;
          state_d = i_Init ? FILL : DRAW;
        end
      end
      FILL: begin
        addr_d  = fill_q;
        data_d  = DATA_W'(rank_q);
        mem_wr  = 1'b1;
        mem_clk = ph_q;
        ph_d    = !ph_q;
        if (ph_q) begin
          rank_d = (rank_q == 4'd13) ? 4'd1 : 4'(rank_q + 4'd1);
          if (32'(fill_q) == LAST_ADDR) state_d = DRAW;
          else fill_d = ADDR_W'(fill_q + 1'b1);
        end
      end
      DRAW: begin
        if (32'(cand) >= 32'(i_q) && 32'(cand) <= LAST_ADDR) begin
          j_d     = cand;
          state_d = RD_I;
        end
      end
      RD_I: begin
        addr_d  = i_q;
        mem_clk = !ph_q;
        ph_d    = !ph_q;
        if (ph_q) begin
          val_i_d = i_MemData;
          state_d = (j_q == i_q) ? NEXT : RD_J;
        end
      end
      RD_J: begin
        addr_d  = j_q;
        mem_clk = !ph_q;
        ph_d    = !ph_q;
        if (ph_q) begin
          val_j_d = i_MemData;
          state_d = WR_J;
        end
      end
      WR_J: begin
        addr_d  = j_q;
        data_d  = val_i_q;
        mem_wr  = 1'b1;
        mem_clk = ph_q;
        ph_d    = !ph_q;
        if (ph_q) state_d = WR_I;
      end
      WR_I: begin
        addr_d  = i_q;
        data_d  = val_j_q;
        mem_wr  = 1'b1;
        mem_clk = ph_q;
        ph_d    = !ph_q;
        if (ph_q) state_d = NEXT;
      end
      NEXT: begin
        if (32'(i_q) < LAST_I) begin
          i_d     = ADDR_W'(i_q + 1'b1);
          state_d = DRAW;
        end else if (32'(pass_q) < PASSES - 1) begin
          pass_d  = 4'(pass_q + 4'd1);
          i_d     = '0;
          state_d = DRAW;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/data are presented combinationally during an access and
  // otherwise replay the registered copy of the last driven value.
  assign o_Address  = addr_d;
  assign o_Data     = data_d;
  assign o_MemClk   = mem_clk;
  assign o_Write    = mem_wr;
  assign o_Busy     = (state_q != IDLE) && (state_q != DONE);
  assign o_Shuffled = (state_q == DONE);
  assign vo_Addr_I  = i_q;

endmodule

// File: doc/deck_shuffler_p.md
DECK_SHUFFLER_P -- requirements
Module: deck_shuffler_p

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W  4  card word width
  ADDR_W  6  memory address width; 1..16
  DECK_SIZE  52  number of cards, 2..2^ADDR_W
  PASSES  1  full Fisher-Yates passes per start, 1..15
  LFSR_SEED  16'hACE1  LFSR reset value; nonzero
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  i_Rst_n  in  1  synchronous active-low reset
  i_Start  in  1  start request, sampled only in IDLE or DONE
  i_Init  in  1  sampled with i_Start; 1 = fill deck before shuffling
  i_ExtJ  in  1  sampled with i_Start; 1 = swap index from i_Addr_J, 0 = internal LFSR
  i_Addr_J  in  ADDR_W  external swap index
  i_MemData  in  DATA_W  card memory read data
  o_Address  out  ADDR_W  card memory address
  o_Data  out  DATA_W  card memory write data
  o_MemClk  out  1  card memory clock strobe
  o_Write  out  1  card memory write enable
  o_Busy  out  1  operation in progress
  o_Shuffled  out  1  shuffle complete, held until next start
  vo_Addr_I  out  ADDR_W  current index i, debug
REQ-003 One clock and one reset SHALL exist; reset SHALL be synchronous and active-low (i_Rst_n sampled on rising clk).

Function
REQ-004 Memory read of address A SHALL take 2 cycles: cycle 1 o_Address=A, o_MemClk=1, o_Write=0; cycle 2 o_Address=A, o_MemClk=0; i_MemData registered at end of cycle 2.
REQ-005 Memory write SHALL take 2 cycles: o_Address, o_Data, o_Write=1 stable for both; o_MemClk=0 cycle 1, o_MemClk=1 cycle 2.
REQ-006 Outside memory access, o_MemClk=0 and o_Write=0.
REQ-007 FSM states SHALL be IDLE, FILL, DRAW, RD_I, RD_J, WR_J, WR_I, NEXT, DONE; each RD/WR/FILL state spans the 2 cycles of REQ-004/005.
REQ-008 IDLE/DONE + i_Start=1 -> capture i_Init, i_ExtJ; i=0, pass=0, rank=1; go FILL if i_Init else DRAW; o_Shuffled=0, o_Busy=1 from next cycle.
REQ-009 FILL SHALL write addresses 0..DECK_SIZE-1 in order with data = rank; rank counts 1..13 then wraps to 1; then DRAW.
REQ-010 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, SHALL advance every cycle regardless of state.
REQ-011 DRAW: candidate = LFSR[ADDR_W-1:0] (internal) or i_Addr_J (external); accept iff i <= candidate <= DECK_SIZE-1, latch as j, go RD_I; else stay in DRAW and retry next cycle.
REQ-012 RD_I latches mem[i]; RD_J latches mem[j]; WR_J writes old mem[i] to j; WR_I writes old mem[j] to i.
REQ-013 If j==i, RD_J, WR_J, WR_I SHALL be skipped (RD_I -> NEXT); memory unchanged.
REQ-014 NEXT: if i < DECK_SIZE-2 then i+1, DRAW; else if pass < PASSES-1 then pass+1, i=0, DRAW; else DONE.
REQ-015 DONE: o_Shuffled=1, o_Busy=0; held until i_Start.
REQ-016 i_Start, i_Init, i_ExtJ SHALL be ignored while o_Busy=1.
REQ-017 Resulting memory SHALL be a permutation of its pre-shuffle contents (multiset preserved).
REQ-018 vo_Addr_I SHALL equal i at all times; o_Address, o_Data SHALL hold last value when idle.

Reset
REQ-019 i_Rst_n=0 on rising clk: state=IDLE, LFSR=LFSR_SEED, i=j=pass=0, rank=1, all outputs 0; applies mid-operation; interrupted memory contents undefined.

Verification
REQ-020 Reset, i_Start=1, i_Init=1, i_ExtJ=0 -> FILL writes mem[0..51] = 1..13 x4; o_Shuffled=1 at end; each rank 1..13 appears exactly 4 times.
REQ-021 Fill mem[k]=k mod 16, i_ExtJ=1, i_Addr_J=51 constant -> each swap i<->51; final mem verified against golden model; no access to address >51.
REQ-022 i_ExtJ=1, i_Addr_J=i each cycle -> no write cycles (o_Write never 1), DONE after 51 x (1+2+1) cycles plus start.
REQ-023 i_ExtJ=1, i_Addr_J=60 then 20 at i=0 -> FSM stays in DRAW while 60; accepts 20; swaps mem[0], mem[20].
REQ-024 PASSES=3, i_Init=1 -> vo_Addr_I sweeps 0..50 three times; permutation property holds.
REQ-025 i_Rst_n=0 during WR_J -> next cycle IDLE, o_Busy=0, o_Write=0, o_MemClk=0; i_Start while busy ignored (o_Shuffled timing unchanged).
